// File: rtl/hilo_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hilo_issue_ctrl_if
// Description : Handshake/status bundle between the hazard unit (master) and
//               the HI/LO issue/stall controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface hilo_issue_ctrl_if #(
    parameter int CNT_W = 16
);
    // D/E stage op codes and E-stage validity
    logic [4:0]       d_op;
    logic [4:0]       e_op;
    logic             e_valid;
    // Controller results
    logic [4:0]       unit_op;
    logic             stall_d;
    logic             busy;
    logic             done;
    logic [3:0]       remain;
    logic             err;
    logic [CNT_W-1:0] n_mul;
    logic [CNT_W-1:0] n_div;

    // Pipeline / hazard side
    modport master (
        output d_op, e_op, e_valid,
        input  unit_op, stall_d, busy, done, remain, err, n_mul, n_div
    );

    // Controller side
    modport slave (
        input  d_op, e_op, e_valid,
        output unit_op, stall_d, busy, done, remain, err, n_mul, n_div
    );
endinterface
`default_nettype wire

// File: rtl/hilo_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hilo_issue_ctrl
// Description : Issue/stall controller for the shared multi-cycle HI/LO
//               multiply-divide unit. Forwards the E-stage op, mirrors the
//               unit's busy countdown, stalls D-stage HILO ops while the unit
//               is occupied, and reports completion, protocol errors and
//               issue statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    hilo_issue_ctrl_if.slave  bus
);

    // HILO op encoding shared with the decoder
    localparam logic [4:0] c_HILO_NONE  = 5'd0;
    localparam logic [4:0] c_HILO_MULT  = 5'd1;
    localparam logic [4:0] c_HILO_MULTU = 5'd2;
    localparam logic [4:0] c_HILO_DIV   = 5'd3;
    localparam logic [4:0] c_HILO_DIVU  = 5'd4;
    localparam logic [4:0] c_HILO_MFHI  = 5'd5;
    localparam logic [4:0] c_HILO_MFLO  = 5'd6;
    localparam logic [4:0] c_HILO_MTHI  = 5'd7;
    localparam logic [4:0] c_HILO_MTLO  = 5'd8;

    localparam logic [3:0] c_MUL_LAT = 4'(MUL_LAT);
    localparam logic [3:0] c_DIV_LAT = 4'(DIV_LAT);
    localparam logic [3:0] c_ONE     = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic             r_err;
    logic [CNT_W-1:0] r_n_mul;
    logic [CNT_W-1:0] r_n_div;

    logic w_is_mul;
    logic w_is_div;
    logic w_is_mov;
    logic w_start;
    logic w_cnt_nz;
    logic w_accept;
    logic w_busy;

    // Classify the E-stage op
    always_comb begin
        w_is_mul = (bus.e_op == c_HILO_MULT) || (bus.e_op == c_HILO_MULTU);
        w_is_div = (bus.e_op == c_HILO_DIV)  || (bus.e_op == c_HILO_DIVU);
        w_is_mov = (bus.e_op == c_HILO_MFHI) || (bus.e_op == c_HILO_MFLO) ||
                   (bus.e_op == c_HILO_MTHI) || (bus.e_op == c_HILO_MTLO);
    end

    // A start only launches the unit when nothing is running; a start during a
    // run is a protocol error and the unit itself ignores it.
    assign w_start  = bus.e_valid & (w_is_mul | w_is_div);
    assign w_cnt_nz = (r_cnt != 4'd0);
    assign w_accept = w_start & ~w_cnt_nz;
    assign w_busy   = w_start | w_cnt_nz;

    // State and countdown register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state / countdown logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_state_nxt = ST_MUL_RUN;
                        w_cnt_nxt   = c_MUL_LAT;
                    end else begin
                        w_state_nxt = ST_DIV_RUN;
                        w_cnt_nxt   = c_DIV_LAT;
                    end
                end
            end
            ST_MUL_RUN, ST_DIV_RUN: begin
                w_cnt_nxt = r_cnt - c_ONE;
                if (r_cnt == c_ONE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Sticky protocol-violation flag: any issue attempt into a running unit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_cnt_nz && (w_start || (bus.e_valid && w_is_mov))) begin
            r_err <= 1'b1;
        end
    end

    // Issue statistics, counting only ops that actually launched the unit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_mul <= '0;
            r_n_div <= '0;
        end else begin
            if (w_accept && w_is_mul) begin
                r_n_mul <= r_n_mul + CNT_W'(1);
            end
            if (w_accept && w_is_div) begin
                r_n_div <= r_n_div + CNT_W'(1);
            end
        end
    end

    // Outputs; unit_op is forwarded even during an error since the unit drops it
    assign bus.unit_op = bus.e_valid ? bus.e_op : c_HILO_NONE;
    assign bus.busy    = w_busy;
    assign bus.stall_d = w_busy & (bus.d_op != c_HILO_NONE);
    assign bus.done    = (r_state != ST_IDLE) & (r_cnt == c_ONE);
    assign bus.remain  = r_cnt;
    assign bus.err     = r_err;
    assign bus.n_mul   = r_n_mul;
    assign bus.n_div   = r_n_div;

endmodule
`default_nettype wire

// File: tb/tb_hilo_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_issue_ctrl
// Description : Self-checking bench for hilo_issue_ctrl. A timeline model
//               (issue cycle + latency) predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_issue_ctrl;

    localparam int CW = 8;

    localparam logic [4:0] NONE  = 5'd0;
    localparam logic [4:0] MULT  = 5'd1;
    localparam logic [4:0] MULTU = 5'd2;
    localparam logic [4:0] DIV   = 5'd3;
    localparam logic [4:0] DIVU  = 5'd4;
    localparam logic [4:0] MFLO  = 5'd6;
    localparam logic [4:0] MTHI  = 5'd7;

    logic clk;
    logic rst;

    hilo_issue_ctrl_if #(.CNT_W(CW)) bus ();

    hilo_issue_ctrl #(
        .MUL_LAT (5),
        .DIV_LAT (10),
        .CNT_W   (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: when the running op was issued and how long it takes
    longint        cyc     = 0;
    longint        m_issue = -1;
    int            m_lat   = 0;
    bit            m_err   = 1'b0;
    logic [CW-1:0] m_nmul  = '0;
    logic [CW-1:0] m_ndiv  = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit m_active();
        return (m_issue >= 0) && (cyc > m_issue) && (cyc <= m_issue + m_lat);
    endfunction

    // Drive one cycle of inputs, check all outputs against the model, advance model
    task automatic cycle(input logic [4:0] d, input logic [4:0] e, input logic v, input logic r);
        bit     act, start, mov, busy_e;
        longint rem;
        @(negedge clk);
        bus.d_op    = d;
        bus.e_op    = e;
        bus.e_valid = v;
        rst         = r;
        #1;
        act    = m_active();
        start  = v && (e >= MULT) && (e <= DIVU);
        mov    = v && (e >= 5'd5) && (e <= 5'd8);
        busy_e = start || act;
        rem    = act ? (m_issue + m_lat + 1 - cyc) : 0;
        if (!r) begin
            check_eq("unit_op", 32'(bus.unit_op), v ? 32'(e) : 32'(NONE));
            check_eq("busy",    32'(bus.busy),    32'(busy_e));
            check_eq("stall_d", 32'(bus.stall_d), 32'(busy_e && (d != NONE)));
            check_eq("done",    32'(bus.done),    32'(act && (cyc == m_issue + m_lat)));
            check_eq("remain",  32'(bus.remain),  32'(rem));
            check_eq("err",     32'(bus.err),     32'(m_err));
            check_eq("n_mul",   32'(bus.n_mul),   32'(m_nmul));
            check_eq("n_div",   32'(bus.n_div),   32'(m_ndiv));
        end
        if (r) begin
            m_issue = -1;
            m_err   = 1'b0;
            m_nmul  = '0;
            m_ndiv  = '0;
        end else begin
            if (act && (start || mov)) m_err = 1'b1;
            if (start && !act) begin
                m_issue = cyc;
                if (e == MULT || e == MULTU) begin
                    m_lat  = 5;
                    m_nmul = m_nmul + 1'b1;
                end else begin
                    m_lat  = 10;
                    m_ndiv = m_ndiv + 1'b1;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic [4:0] d);
        for (int i = 0; i < n; i++) cycle(d, NONE, 1'b0, 1'b0);
    endtask

    initial begin
        logic [4:0] e, d;
        logic       v, r;
        int         sel;
        int         issued;

        bus.d_op    = NONE;
        bus.e_op    = NONE;
        bus.e_valid = 1'b0;
        rst         = 1'b1;

        // Reset, then reset in the middle of a divide
        cycle(NONE, NONE, 1'b0, 1'b1);
        idle(1, NONE);
        cycle(NONE, DIV, 1'b1, 1'b0);
        idle(3, NONE);
        cycle(NONE, NONE, 1'b0, 1'b1);
        idle(2, NONE);

        // Mult with a dependent mflo waiting in D
        cycle(MFLO, MULT, 1'b1, 1'b0);
        idle(7, MFLO);

        // Divu with a non-HILO instruction in D
        cycle(NONE, DIVU, 1'b1, 1'b0);
        idle(11, NONE);

        // Divide forced into a running multiply
        cycle(NONE, MULT, 1'b1, 1'b0);
        idle(1, NONE);
        cycle(NONE, DIV, 1'b1, 1'b0);
        idle(6, NONE);

        // Flushed divide, then mthi while idle
        cycle(NONE, NONE, 1'b0, 1'b1);
        cycle(NONE, DIV, 1'b0, 1'b0);
        cycle(NONE, MTHI, 1'b1, 1'b0);
        idle(2, MFLO);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 55)      e = NONE;
            else if (sel < 80) e = 5'($urandom_range(1, 4));
            else if (sel < 95) e = 5'($urandom_range(5, 8));
            else               e = 5'($urandom_range(9, 31));
            v = ($urandom_range(0, 9) != 0);
            d = ($urandom_range(0, 9) < 4) ? NONE : 5'($urandom_range(1, 8));
            r = ($urandom_range(0, 199) == 0);
            cycle(d, e, v, r);
        end

        // Back-to-back multiplies until the counter wraps
        cycle(NONE, NONE, 1'b0, 1'b1);
        issued = 0;
        while (issued < (1 << CW)) begin
            if (!m_active()) begin
                cycle(MFLO, ($urandom_range(0, 1) != 0) ? MULT : MULTU, 1'b1, 1'b0);
                issued++;
            end else begin
                cycle(MFLO, NONE, 1'b0, 1'b0);
            end
        end
        idle(6, NONE);
        check_eq("n_mul_wrap", 32'(bus.n_mul), 32'd0);
        check_eq("err_wrap",   32'(bus.err),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
